// File: rtl/cmd_dispatch_pkg.sv
// ============================================================================
// Module  : cmd_dispatch_pkg
// Brief   : Shared state encoding, default response bytes and opcode check
//           for the command dispatcher.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cmd_dispatch_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        RESP      = 3'd3,
        RESP_WAIT = 3'd4,
        TLM       = 3'd5
    } state_t;

    localparam logic [7:0]  c_ack_byte   = 8'hA5;
    localparam logic [7:0]  c_nak_byte   = 8'hEE;
    localparam logic [7:0]  c_tmo_byte   = 8'hEF;
    localparam logic [7:0]  c_max_op     = 8'h08;
    localparam logic [23:0] c_tmo_cycles = 24'd5_000_000;

    // Legal opcodes are 1..max_op; zero is reserved.
    function automatic logic op_legal(input logic [7:0] op, input logic [7:0] max_op);
        return (op != 8'h00) && (op <= max_op);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dispatch_tmo.sv
// ============================================================================
// Module  : dispatch_tmo
// Brief   : Command timeout counter; cleared on ISSUE entry, counts while an
//           operation is outstanding and saturates at TMO_CYCLES-1.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dispatch_tmo #(
    parameter logic [23:0] TMO_CYCLES = 24'd5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_run,
    output logic o_expired
);

    logic [23:0] r_cnt;
    logic        w_at_max;

    assign w_at_max  = (r_cnt == (TMO_CYCLES - 24'd1));
    assign o_expired = w_at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run && !w_at_max) begin
            r_cnt <= r_cnt + 24'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cmd_dispatch.sv
// ============================================================================
// Module  : cmd_dispatch
// Brief   : Arbitrates UART commands and telemetry bytes, issues operations to
//           the flight controller and returns one response byte per request.
//           Optional timeout enabled by defining CMD_DISPATCH_TMO_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_dispatch
    import cmd_dispatch_pkg::*;
#(
    parameter logic [7:0]  ACK_BYTE   = c_ack_byte,
    parameter logic [7:0]  NAK_BYTE   = c_nak_byte,
    parameter logic [7:0]  TMO_BYTE   = c_tmo_byte,
    parameter logic [7:0]  MAX_OP     = c_max_op,
    parameter logic [23:0] TMO_CYCLES = c_tmo_cycles
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_rdy,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic [7:0]  resp,
    input  logic        resp_sent,
    output logic        op_vld,
    output logic [7:0]  op_code,
    output logic [15:0] op_data,
    input  logic        op_rdy,
    input  logic        op_done,
    input  logic        op_err,
    input  logic        tlm_req,
    input  logic [7:0]  tlm_byte,
    output logic        tlm_gnt,
    output logic        busy
);

    state_t      r_state,       w_state_nxt;
    logic        r_last_tlm,    w_last_tlm_nxt;
    logic        r_clr_cmd_rdy, w_clr_cmd_rdy_nxt;
    logic        r_send_resp,   w_send_resp_nxt;
    logic        r_op_vld,      w_op_vld_nxt;
    logic        r_tlm_gnt,     w_tlm_gnt_nxt;
    logic [7:0]  r_resp,        w_resp_nxt;
    logic [7:0]  r_op_code,     w_op_code_nxt;
    logic [15:0] r_op_data,     w_op_data_nxt;

    logic        w_pick_cmd;
    logic        w_pick_tlm;
    logic        w_tmo_hit;

    // On a conflict the source not granted last time wins.
    assign w_pick_tlm = tlm_req && (!cmd_rdy || !r_last_tlm);
    assign w_pick_cmd = cmd_rdy && (!tlm_req ||  r_last_tlm);

`ifdef CMD_DISPATCH_TMO_EN
    logic w_tmo_clr;
    logic w_tmo_run;

    assign w_tmo_clr = (r_state == IDLE) && (w_state_nxt == ISSUE);
    assign w_tmo_run = (r_state == ISSUE) || (r_state == WAIT_DONE);

    dispatch_tmo #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_tmo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_tmo_clr),
        .i_run     (w_tmo_run),
        .o_expired (w_tmo_hit)
    );
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_last_tlm_nxt    = r_last_tlm;
        w_clr_cmd_rdy_nxt = 1'b0;
        w_send_resp_nxt   = 1'b0;
        w_op_vld_nxt      = 1'b0;
        w_tlm_gnt_nxt     = 1'b0;
        w_resp_nxt        = r_resp;
        w_op_code_nxt     = r_op_code;
        w_op_data_nxt     = r_op_data;

        case (r_state)
            IDLE: begin
                if (w_pick_tlm) begin
                    w_tlm_gnt_nxt  = 1'b1;
                    w_resp_nxt     = tlm_byte;
                    w_last_tlm_nxt = 1'b1;
                    w_state_nxt    = TLM;
                end else if (w_pick_cmd) begin
                    w_clr_cmd_rdy_nxt = 1'b1;
                    w_op_code_nxt     = cmd;
                    w_op_data_nxt     = data;
                    w_last_tlm_nxt    = 1'b0;
                    if (op_legal(cmd, MAX_OP)) begin
                        w_op_vld_nxt = 1'b1;
                        w_state_nxt  = ISSUE;
                    end else begin
                        w_resp_nxt      = NAK_BYTE;
                        w_send_resp_nxt = 1'b1;
                        w_state_nxt     = RESP;
                    end
                end
            end

            // op_done is deliberately not looked at until the handshake is over.
            ISSUE: begin
                if (op_rdy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (w_tmo_hit) begin
                    w_resp_nxt      = TMO_BYTE;
                    w_send_resp_nxt = 1'b1;
                    w_state_nxt     = RESP;
                end else begin
                    w_op_vld_nxt = 1'b1;
                end
            end

            WAIT_DONE: begin
                if (op_done) begin
                    w_resp_nxt      = op_err ? NAK_BYTE : ACK_BYTE;
                    w_send_resp_nxt = 1'b1;
                    w_state_nxt     = RESP;
                end else if (w_tmo_hit) begin
                    w_resp_nxt      = TMO_BYTE;
                    w_send_resp_nxt = 1'b1;
                    w_state_nxt     = RESP;
                end
            end

            RESP: begin
                w_state_nxt = RESP_WAIT;
            end

            RESP_WAIT: begin
                if (resp_sent) begin
                    w_state_nxt = IDLE;
                end
            end

            TLM: begin
                w_send_resp_nxt = 1'b1;
                w_state_nxt     = RESP;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last_tlm    <= 1'b0;
            r_clr_cmd_rdy <= 1'b0;
            r_send_resp   <= 1'b0;
            r_op_vld      <= 1'b0;
            r_tlm_gnt     <= 1'b0;
            r_resp        <= 8'h00;
            r_op_code     <= 8'h00;
            r_op_data     <= 16'h0000;
        end else begin
            r_state       <= w_state_nxt;
            r_last_tlm    <= w_last_tlm_nxt;
            r_clr_cmd_rdy <= w_clr_cmd_rdy_nxt;
            r_send_resp   <= w_send_resp_nxt;
            r_op_vld      <= w_op_vld_nxt;
            r_tlm_gnt     <= w_tlm_gnt_nxt;
            r_resp        <= w_resp_nxt;
            r_op_code     <= w_op_code_nxt;
            r_op_data     <= w_op_data_nxt;
        end
    end

    assign clr_cmd_rdy = r_clr_cmd_rdy;
    assign send_resp   = r_send_resp;
    assign resp        = r_resp;
    assign op_vld      = r_op_vld;
    assign op_code     = r_op_code;
    assign op_data     = r_op_data;
    assign tlm_gnt     = r_tlm_gnt;
    assign busy        = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cmd_dispatch.sv
// ============================================================================
// Module  : tb_cmd_dispatch
// Brief   : Scoreboard bench for cmd_dispatch with UART, flight-controller and
//           transmitter models. Define CMD_DISPATCH_TMO_EN to cover the timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmd_dispatch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_rdy = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic [15:0] data = 16'h0000;
    logic        resp_sent = 1'b0;
    logic        op_rdy = 1'b0;
    logic        op_done = 1'b0;
    logic        op_err = 1'b0;
    logic        tlm_req = 1'b0;
    logic [7:0]  tlm_byte = 8'h00;

    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        op_vld;
    logic [7:0]  op_code;
    logic [15:0] op_data;
    logic        tlm_gnt;
    logic        busy;

    always #5 clk = ~clk;

    cmd_dispatch #(
        .TMO_CYCLES (24'd100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .clr_cmd_rdy (clr_cmd_rdy),
        .send_resp   (send_resp),
        .resp        (resp),
        .resp_sent   (resp_sent),
        .op_vld      (op_vld),
        .op_code     (op_code),
        .op_data     (op_data),
        .op_rdy      (op_rdy),
        .op_done     (op_done),
        .op_err      (op_err),
        .tlm_req     (tlm_req),
        .tlm_byte    (tlm_byte),
        .tlm_gnt     (tlm_gnt),
        .busy        (busy)
    );

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_resp[$];
    logic [23:0] exp_op[$];
    int          n_clr = 0;
    int          n_vld = 0;
    logic        pend = 1'b0;
    logic [7:0]  held = 8'h00;
    int          fc_mode = 0;   // 0: accept+done, 1: accept only, 2: never accept
    logic        fc_err = 1'b0;
    int          lat;
    int          c0;
    int          v0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [15:0] d, output int l);
        cmd = c;
        data = d;
        cmd_rdy = 1'b1;
        l = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            l++;
            if (clr_cmd_rdy) break;
        end
        check("cmd_grant", {31'd0, clr_cmd_rdy}, 32'd1);
        cmd_rdy = 1'b0;
    endtask

    task automatic send_tlm(input logic [7:0] b);
        tlm_byte = b;
        tlm_req = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (tlm_gnt) break;
        end
        check("tlm_grant", {31'd0, tlm_gnt}, 32'd1);
        tlm_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!busy && exp_resp.size() == 0 && exp_op.size() == 0 && !pend) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    // Flight controller: accepts two cycles after op_vld; drives a stray
    // op_done/op_err in the handshake cycle, which the dispatcher must ignore.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (op_vld && fc_mode != 2) begin
                repeat (2) begin @(posedge clk); #1; end
                op_rdy = 1'b1;
                op_done = 1'b1;
                op_err = 1'b1;
                @(posedge clk); #1;
                op_rdy = 1'b0;
                op_done = 1'b0;
                op_err = 1'b0;
                if (fc_mode == 0) begin
                    repeat (3) begin @(posedge clk); #1; end
                    op_done = 1'b1;
                    op_err = fc_err;
                    @(posedge clk); #1;
                    op_done = 1'b0;
                    op_err = 1'b0;
                end
            end
        end
    end

    // Transmitter: reports completion a few cycles after each send_resp.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (send_resp) begin
                repeat (3) begin @(posedge clk); #1; end
                resp_sent = 1'b1;
                @(posedge clk); #1;
                resp_sent = 1'b0;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (clr_cmd_rdy) n_clr++;
                    if (op_vld) n_vld++;
                    if (op_vld && op_rdy) begin
                        check("op_expected", {31'd0, exp_op.size() != 0}, 32'd1);
                        if (exp_op.size() != 0) check("op_code_data", {8'h00, op_code, op_data}, {8'h00, exp_op.pop_front()});
                    end
                    if (send_resp) begin
                        check("send_without_sent", {31'd0, pend}, 32'd0);
                        pend = 1'b1;
                        held = resp;
                        check("resp_expected", {31'd0, exp_resp.size() != 0}, 32'd1);
                        if (exp_resp.size() != 0) check("resp", {24'd0, resp}, {24'd0, exp_resp.pop_front()});
                    end
                    if (resp_sent && pend) begin
                        check("resp_stable", {24'd0, resp}, {24'd0, held});
                        pend = 1'b0;
                    end
                end else begin
                    pend = 1'b0;
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {27'd0, clr_cmd_rdy, send_resp, op_vld, tlm_gnt, busy}, 32'd0);
        check("rst_op_code", {24'd0, op_code}, 32'd0);
        check("rst_op_data", {16'd0, op_data}, 32'd0);
        check("rst_resp", {24'd0, resp}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic legal command
        c0 = n_clr;
        exp_op.push_back({8'h03, 16'h1234});
        exp_resp.push_back(8'hA5);
        send_cmd(8'h03, 16'h1234, lat);
        check("grant_latency", lat, 32'd1);
        wait_idle("idle_after_cmd03");
        check("clr_pulses_cmd03", n_clr - c0, 32'd1);
        check("op_code_hold", {24'd0, op_code}, 32'h03);
        check("op_data_hold", {16'd0, op_data}, 32'h1234);

        // Illegal opcodes, then the highest legal one
        c0 = n_clr;
        v0 = n_vld;
        exp_resp.push_back(8'hEE);
        send_cmd(8'h00, 16'h0001, lat);
        wait_idle("idle_after_cmd00");
        exp_resp.push_back(8'hEE);
        send_cmd(8'h09, 16'h0002, lat);
        wait_idle("idle_after_cmd09");
        check("no_op_vld_illegal", n_vld - v0, 32'd0);
        check("clr_pulses_illegal", n_clr - c0, 32'd2);
        check("op_code_latch_illegal", {24'd0, op_code}, 32'h09);
        exp_op.push_back({8'h08, 16'hFFFF});
        exp_resp.push_back(8'hA5);
        send_cmd(8'h08, 16'hFFFF, lat);
        wait_idle("idle_after_cmd08");

        // Operation error
        fc_err = 1'b1;
        exp_op.push_back({8'h05, 16'hABCD});
        exp_resp.push_back(8'hEE);
        send_cmd(8'h05, 16'hABCD, lat);
        wait_idle("idle_after_err");
        fc_err = 1'b0;

        // Conflicts: telemetry wins first, then the waiting command
        exp_resp.push_back(8'h5C);
        exp_resp.push_back(8'hA5);
        exp_resp.push_back(8'h5D);
        exp_op.push_back({8'h02, 16'h0F0F});
        fork
            send_cmd(8'h02, 16'h0F0F, lat);
            begin
                send_tlm(8'h5C);
                send_tlm(8'h5D);
            end
        join
        wait_idle("idle_after_arb");

        // Reset in the middle of WAIT_DONE
        fc_mode = 1;
        exp_op.push_back({8'h04, 16'h5555});
        send_cmd(8'h04, 16'h5555, lat);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (exp_op.size() == 0) break;
        end
        check("handshake_before_reset", {31'd0, exp_op.size() == 0}, 32'd1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {27'd0, clr_cmd_rdy, send_resp, op_vld, tlm_gnt, busy}, 32'd0);
        check("midrst_op", {8'd0, op_code, op_data}, 32'd0);
        check("midrst_resp", {24'd0, resp}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fc_mode = 0;
        @(posedge clk); #1;
        exp_op.push_back({8'h06, 16'h0001});
        exp_resp.push_back(8'hA5);
        send_cmd(8'h06, 16'h0001, lat);
        wait_idle("idle_after_reset_cmd");
        check("op_code_after_reset", {24'd0, op_code}, 32'h06);

`ifdef CMD_DISPATCH_TMO_EN
        // Flight controller never accepts: timeout after 100 cycles
        fc_mode = 2;
        v0 = n_vld;
        exp_resp.push_back(8'hEF);
        send_cmd(8'h01, 16'h0BAD, lat);
        wait_idle("idle_after_tmo");
        check("tmo_op_vld_cycles", n_vld - v0, 32'd100);
        check("tmo_op_vld_low", {31'd0, op_vld}, 32'd0);
        fc_mode = 0;
`endif

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cmd_dispatch.md
CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ACK_BYTE, 8'hA5, response byte sent after a successful command.
- NAK_BYTE, 8'hEE, response byte sent for an illegal opcode or when op_err is set.
- TMO_BYTE, 8'hEF, response byte sent on a command timeout.
- MAX_OP, 8'h08, highest legal opcode; legal opcodes are 8'h01..MAX_OP.
- TMO_CYCLES, 24'd5_000_000, command timeout in clk cycles.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- cmd_rdy, in, 1, command available from the UART link.
- cmd, in, 8, opcode.
- data, in, 16, command parameter.
- clr_cmd_rdy, out, 1, command consumed.
- send_resp, out, 1, start transmission of one byte.
- resp, out, 8, byte to transmit.
- resp_sent, in, 1, transmission complete.
- op_vld, out, 1, operation offered to the flight controller.
- op_code, out, 8, latched opcode.
- op_data, out, 16, latched parameter.
- op_rdy, in, 1, flight controller accepts the operation.
- op_done, in, 1, operation complete.
- op_err, in, 1, operation failed; sampled together with op_done.
- tlm_req, in, 1, telemetry byte pending.
- tlm_byte, in, 8, telemetry byte.
- tlm_gnt, out, 1, telemetry byte taken.
- busy, out, 1, high whenever the state is not IDLE.

Function
REQ-003 The state machine SHALL have exactly the states IDLE, ISSUE, WAIT_DONE, RESP, RESP_WAIT and TLM.
REQ-004 In IDLE with cmd_rdy=1 and the command selected, the block SHALL, on the next edge, latch cmd into op_code and data into op_data, and SHALL pulse clr_cmd_rdy for exactly 1 cycle.
- Legal opcode: go to ISSUE.
- Illegal opcode (8'h00 or greater than MAX_OP): go to RESP with NAK_BYTE, and SHALL NOT assert op_vld.
REQ-005 ISSUE SHALL hold op_vld=1 until a cycle with op_vld&op_rdy, then drop op_vld on the next edge and go to WAIT_DONE; op_done in the handshake cycle SHALL be ignored.
REQ-006 WAIT_DONE SHALL wait for op_done=1, then go to RESP with resp=ACK_BYTE if op_err=0, or NAK_BYTE if op_err=1.
REQ-007 RESP SHALL pulse send_resp for exactly 1 cycle with resp stable, then go to RESP_WAIT.
REQ-008 resp SHALL hold its value until resp_sent=1, after which the block goes to IDLE.
REQ-009 In IDLE with tlm_req=1 and telemetry selected, the block SHALL pulse tlm_gnt for 1 cycle, load resp<=tlm_byte, and go to RESP.
REQ-010 Arbitration when cmd_rdy and tlm_req are both high in IDLE: the source NOT granted last SHALL win (1-bit last_tlm flag, reset 0, so the first conflict is won by telemetry); a lone requester SHALL always win.
REQ-011 A cmd_rdy or tlm_req arriving while busy=1 SHALL be left pending and serviced in IDLE; no request SHALL be dropped.
REQ-012 IDLE-to-grant latency SHALL be 1 cycle; there SHALL be no back-to-back send_resp without an intervening resp_sent.

Reset
REQ-013 Asserting rst_n low at any time, including mid-operation, SHALL immediately force state=IDLE and last_tlm=0.
REQ-014 Reset SHALL immediately force clr_cmd_rdy, send_resp, op_vld, tlm_gnt and busy to 0, and op_code, op_data and resp to 8'h00/16'h0000/8'h00.

Configuration
REQ-015 With macro CMD_DISPATCH_TMO_EN defined, a counter cleared on entry to ISSUE SHALL count in ISSUE and WAIT_DONE.
- On reaching TMO_CYCLES-1 it SHALL drop op_vld and go to RESP with TMO_BYTE.
- A simultaneous op_done SHALL take precedence over the timeout.
REQ-016 Without CMD_DISPATCH_TMO_EN, no counter SHALL exist and ISSUE/WAIT_DONE SHALL wait indefinitely.

Structure
REQ-017 Package cmd_dispatch_pkg SHALL hold the state enum and the default ACK/NAK/TMO byte constants.
REQ-018 The timeout counter SHALL be sub-module dispatch_tmo, instantiated only under CMD_DISPATCH_TMO_EN.

Verification
REQ-019 Cmd 8'h03/data 16'h1234, op_rdy after 2 cycles, op_done op_err=0 -> op_code=8'h03, op_data=16'h1234, one clr_cmd_rdy pulse, send_resp with resp=8'hA5.
REQ-020 Cmd 8'h00 and cmd 8'h09 -> no op_vld, resp=8'hEE for each.
REQ-021 cmd_rdy and tlm_req (tlm_byte 8'h5C) in the same cycle, twice -> telemetry 8'h5C first, then command ACK; on the next conflict the command wins.
REQ-022 op_done with op_err=1 -> resp=8'hEE; with TMO_EN and TMO_CYCLES=100 and no op_done -> op_vld dropped and resp=8'hEF after 100 cycles.
REQ-023 rst_n low during WAIT_DONE -> all outputs 0 immediately; a fresh command afterwards completes normally.
